chall_checker: RTL and testbench
================================

# chall_checker

Downstream result checker for the `chall` byte-transform core. It consumes the 8-bit result stream one byte per valid cycle and compares each byte against a loadable table of expected bytes. It then reports pass/fail, the number of mismatching bytes and the index of the first mismatch. It replaces per-cycle bench comparison with a synthesizable sequential checker that sits directly on `chall.res`.

## Interface
Parameters:
- `N`, 26: number of bytes per check sequence (2..64).
- `W`, 8: byte width; must equal the `chall` result width.
- `IW`, $clog2(N): index width.
- `CW`, $clog2(N+1): mismatch-counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a check sequence; honoured only in IDLE or DONE.
- `in_valid`  in  1  `in_data` carries a result byte this cycle.
- `in_data`  in  W  result byte, driven by `chall.res`.
- `exp_we`  in  1  write enable for the expected table.
- `exp_addr`  in  IW  table write index; writes with `exp_addr >= N` are ignored.
- `exp_data`  in  W  expected byte to write.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE; this is a level, not a pulse.
- `pass`  out  1  high in DONE when `mism_cnt == 0`; low otherwise.
- `mism_cnt`  out  CW  number of mismatching bytes in the current or last sequence.
- `first_bad`  out  IW  index of the first mismatch.
- `first_bad_vld`  out  1  `first_bad` holds a recorded mismatch.

## Operation
- The state machine has three states: IDLE, RUN and DONE. Reset value is IDLE.
- IDLE, on `start`: go to RUN. Clear `idx`, `mism_cnt`, `first_bad` and `first_bad_vld`.
- DONE, on `start`: same action as in IDLE. This is the restart path.
- RUN, on each `in_valid` cycle:
  - Compare `in_data` with `exp[idx]`.
  - On inequality, increment `mism_cnt`.
  - If `first_bad_vld` is 0, load `first_bad <= idx` and set `first_bad_vld`.
  - Increment `idx`.
- RUN, when the accepted byte has `idx == N-1`: go to DONE instead of incrementing `idx`.
- RUN, on a cycle with `in_valid` low: hold all state. Gaps of any length are legal.
- Ignored inputs:
  - `start` while in RUN (no abort).
  - `in_valid` while in IDLE or DONE.
  - `exp_we` while in RUN, so the table is frozen during a check.
- Expected table: N x W registers, written on `exp_we` in IDLE or DONE. A write in the same cycle as `start` is performed; the sequence started in that cycle uses the newly written value.
- `mism_cnt` saturates at N. It cannot exceed N by construction.
- `pass` is combinational: `(state == DONE) && (mism_cnt == 0)`.
- `busy` and `done` are decoded from the state register.

## Timing
- Reset is asynchronous. While `rst` is high, all of the following are 0 immediately, independent of `clk`:
  - state (IDLE), `busy`, `done`, `pass`;
  - `idx`, `mism_cnt`, `first_bad`, `first_bad_vld`;
  - every expected-table entry.
- Reset during RUN abandons the sequence. After `rst` falls the block is in IDLE, and a fresh table load is required.
- `start` sampled at edge k: `busy` = 1 after edge k. The first byte can be accepted at edge k+1.
- Byte sampled at edge k: `mism_cnt`, `first_bad` and `first_bad_vld` reflect it after edge k.
- The Nth accepted byte at edge k gives `done = 1` and `busy = 0` after edge k, with `pass` valid in the same cycle.
- Total latency: N valid cycles plus one start cycle. There is no additional pipeline delay.
- Results hold in DONE until the next `start` or `rst`.

## Test plan
- Nominal pass:
  - Stimulus: load the table with 77,105,111,105,74,106,115,10,249,10,73,106,125,10,125,73,111,249,74,73,106,249,68,111,125,75. Pulse `start`, then stream the same 26 bytes on consecutive cycles.
  - Required: `done` = 1 exactly after the 26th valid edge; `pass` = 1, `mism_cnt` = 0, `first_bad_vld` = 0.
- Mismatches:
  - Stimulus: same table; stream byte 7 as 11 instead of 10, and byte 20 as 0 instead of 106.
  - Required: `mism_cnt` = 2, `first_bad` = 7, `first_bad_vld` = 1, `pass` = 0, `done` = 1.
- Gapped valid:
  - Stimulus: nominal data with `in_valid` high every third cycle.
  - Required: identical results to the nominal case; `done` rises only after the 26th valid byte; `busy` = 1 throughout.
- Ignored controls:
  - Stimulus: during RUN at idx 5, assert `start` and `exp_we` with `exp_addr` = 6, `exp_data` = 0.
  - Required: no restart, table unchanged, final `pass` = 1.
- Reset mid-run:
  - Stimulus: assert `rst` asynchronously (off-edge) at idx 12, then release it.
  - Required: all outputs are 0 immediately; state is IDLE; after a new `start` with no reload, the nominal stream gives `mism_cnt` = 26, `first_bad` = 0.
- Restart from DONE:
  - Stimulus: after the mismatch case, pulse `start` and stream the nominal data.
  - Required: counters cleared after the start edge; final `pass` = 1, `mism_cnt` = 0.

Source files
------------

// File: rtl/chall_checker.sv
`default_nettype none
// ============================================================================
// Module   : chall_checker
// Purpose  : Sequential result checker for the chall byte-transform core.
//            Compares N result bytes, one per in_valid cycle, against a
//            loadable table of expected bytes. Reports pass/fail, the number
//            of mismatching bytes and the index of the first mismatch.
// Ports    : clk, rst           - clock (rising edge), async active-high reset
//            start              - begin a sequence (honoured in IDLE/DONE)
//            in_valid, in_data  - result byte stream from chall.res
//            exp_we/addr/data   - expected-table write port (IDLE/DONE only)
//            busy, done, pass   - status (done is a level held until start)
//            mism_cnt           - mismatch count of current/last sequence
//            first_bad(_vld)    - index of first mismatch and its valid flag
// Revision : 1.0 - initial release
// ============================================================================
module chall_checker #(
  parameter int N  = 26,
  parameter int W  = 8,
  parameter int IW = $clog2(N),
  parameter int CW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic          exp_we,
  input  logic [IW-1:0] exp_addr,
  input  logic [W-1:0]  exp_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] mism_cnt,
  output logic [IW-1:0] first_bad,
  output logic          first_bad_vld
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_exp [N];
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_mism_cnt;
  logic [IW-1:0] r_first_bad;
  logic          r_first_bad_vld;

  logic          w_start;
  logic          w_accept;
  logic          w_last;
  logic          w_mism;
  logic          w_tbl_we;

  // start is a no-op while a sequence is running (no abort path).
  assign w_start  = start && (r_state != S_RUN);
  assign w_accept = in_valid && (r_state == S_RUN);
  assign w_last   = (r_idx == IW'(N-1));
  assign w_mism   = (in_data != r_exp[r_idx]);
  // Table is frozen during RUN; out-of-range addresses are dropped.
  assign w_tbl_we = exp_we && (r_state != S_RUN) && (int'(exp_addr) < N);

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last) w_state_nxt = S_DONE;
      S_DONE:  if (w_start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Expected table. A write coinciding with start lands before the first
  // compare, which cannot happen earlier than the following edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_exp[i] <= '0;
    end else if (w_tbl_we) begin
      r_exp[exp_addr] <= exp_data;
    end
  end

  // --------------------------------------------------------------------------
  // Index, mismatch counter and first-mismatch capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx           <= '0;
      r_mism_cnt      <= '0;
      r_first_bad     <= '0;
      r_first_bad_vld <= 1'b0;
    end else if (w_start) begin
      r_idx           <= '0;
      r_mism_cnt      <= '0;
      r_first_bad     <= '0;
      r_first_bad_vld <= 1'b0;
    end else if (w_accept) begin
      if (w_mism) begin
        if (r_mism_cnt != CW'(N)) r_mism_cnt <= r_mism_cnt + CW'(1);
        if (!r_first_bad_vld) begin
          r_first_bad     <= r_idx;
          r_first_bad_vld <= 1'b1;
        end
      end
      // The last byte leaves idx at N-1; the next start clears it.
      if (!w_last) r_idx <= r_idx + IW'(1);
    end
  end

  assign busy          = (r_state == S_RUN);
  assign done          = (r_state == S_DONE);
  assign pass          = (r_state == S_DONE) && (r_mism_cnt == '0);
  assign mism_cnt      = r_mism_cnt;
  assign first_bad     = r_first_bad;
  assign first_bad_vld = r_first_bad_vld;

endmodule
`default_nettype wire

// File: tb/tb_chall_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_chall_checker
// Purpose  : Directed self-checking bench for chall_checker. Expected values
//            are hand-derived from the 26-byte reference sequence.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_chall_checker;

  localparam int N  = 26;
  localparam int W  = 8;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N+1);

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          exp_we;
  logic [IW-1:0] exp_addr;
  logic [W-1:0]  exp_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] mism_cnt;
  logic [IW-1:0] first_bad;
  logic          first_bad_vld;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] nom [N] = '{8'd77, 8'd105, 8'd111, 8'd105, 8'd74, 8'd106,
                            8'd115, 8'd10, 8'd249, 8'd10, 8'd73, 8'd106,
                            8'd125, 8'd10, 8'd125, 8'd73, 8'd111, 8'd249,
                            8'd74, 8'd73, 8'd106, 8'd249, 8'd68, 8'd111,
                            8'd125, 8'd75};
  logic [W-1:0] cur [N];

  chall_checker #(.N(N), .W(W), .IW(IW), .CW(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .exp_we        (exp_we),
    .exp_addr      (exp_addr),
    .exp_data      (exp_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .mism_cnt      (mism_cnt),
    .first_bad     (first_bad),
    .first_bad_vld (first_bad_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table();
    for (int i = 0; i < N; i++) begin
      exp_we = 1'b1; exp_addr = IW'(i); exp_data = nom[i];
      tick();
    end
    exp_we = 1'b0;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cnt_clr"}, mism_cnt, 0);
    chk({tag, "_fbv_clr"}, first_bad_vld, 0);
  endtask

  // Stream nbytes of cur[]; gap idle cycles between bytes; at byte index
  // inj_at, first spend one cycle driving start and a table write.
  task automatic stream(input int nbytes, input int gap, input int inj_at);
    for (int i = 0; i < nbytes; i++) begin
      if (i == inj_at) begin
        start = 1'b1; exp_we = 1'b1; exp_addr = IW'(6); exp_data = '0;
        tick();
        start = 1'b0; exp_we = 1'b0;
        chk("inj_busy", busy, 1);
      end
      in_valid = 1'b1; in_data = cur[i];
      tick();
      in_valid = 1'b0; in_data = '0;
      chk("done_at_edge", done, (i == N-1));
      if (i < N-1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("gap_busy", busy, 1);
        end
      end
    end
  endtask

  task automatic check_results(input string tag, input int em, input int efb,
                               input int efbv, input int ep);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pass"}, pass, ep);
    chk({tag, "_mism"}, mism_cnt, em);
    chk({tag, "_fbv"},  first_bad_vld, efbv);
    chk({tag, "_fb"},   first_bad, efb);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    for (int i = 0; i < N; i++) cur[i] = nom[i];
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mism", mism_cnt, 0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Nominal pass; idle-state valid must be ignored.
    load_table();
    in_valid = 1'b1; in_data = 8'd1; tick(); in_valid = 1'b0;
    chk("idle_valid_ign", busy, 0);
    do_start("nom");
    stream(N, 0, -1);
    check_results("nom", 0, 0, 0, 1);
    tick(); tick();
    check_results("nom_hold", 0, 0, 0, 1);

    // Two mismatches, restart from DONE.
    cur[7] = 8'd11; cur[20] = 8'd0;
    do_start("mis");
    stream(N, 0, -1);
    check_results("mis", 2, 7, 1, 0);
    for (int i = 0; i < N; i++) cur[i] = nom[i];

    // Restart from DONE after mismatches.
    do_start("rs");
    stream(N, 0, -1);
    check_results("rs", 0, 0, 0, 1);

    // Gapped valid: one valid every third cycle.
    do_start("gap");
    stream(N, 2, -1);
    check_results("gap", 0, 0, 0, 1);

    // start and table write at idx 5 during RUN must be ignored.
    do_start("ign");
    stream(N, 0, 5);
    check_results("ign", 0, 0, 0, 1);

    // Asynchronous reset mid-run at idx 12.
    do_start("mr");
    stream(12, 0, -1);
    chk("mr_busy_pre", busy, 1);
    #3 rst = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_pass", pass, 0);
    chk("mr_mism", mism_cnt, 0);
    chk("mr_fbv", first_bad_vld, 0);
    chk("mr_fb", first_bad, 0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("mr_idle", busy | done, 0);
    // Table was cleared: every nonzero nominal byte mismatches.
    do_start("mr2");
    stream(N, 0, -1);
    check_results("mr2", 26, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
